// File: rtl/nes_frame_capture.sv
// nes_frame_capture: captures one H_ACTIVE x V_ACTIVE frame of NES palette
// indices into a double-buffered store. Banks swap on every completed frame.
// Random reads are always served from the completed (front) bank.
`timescale 1ns/1ps
module nes_frame_capture #(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 240,
  parameter int PIX_W    = 8,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic [PIX_W-1:0]  pixel_in,
  input  logic              h,
  input  logic              v,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              frame_ready,
  output logic              front_bank,
  output logic [15:0]       frame_count,
  output logic              err_abort,
  output logic              err_short
);

  localparam int XW        = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW        = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;
  // Bank select is the top address bit, so each bank spans the full read address space.
  localparam int MEM_DEPTH = 2 ** (ADDR_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HWAIT, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_h_q;
  logic              r_v_q;
  logic              w_h_rise;
  logic              w_v_rise;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [XW-1:0]     w_x_next;
  logic [YW-1:0]     w_y_next;
  // Position that a pix_en arriving this cycle would land on, after strobes are applied.
  logic [XW-1:0]     w_wx;
  logic [YW-1:0]     w_wy;
  logic              w_capture;
  logic              w_set_abort;
  logic              w_set_short;
  logic              w_wr_en;
  logic              w_swap;
  logic [ADDR_W-1:0] w_wr_addr;

  logic              r_front_bank;
  logic [15:0]       r_frame_count;
  logic              r_err_abort;
  logic              r_err_short;
  logic [PIX_W-1:0]  r_rd_data;
  logic              r_rd_valid;

  logic [PIX_W-1:0]  r_mem [MEM_DEPTH];

  assign w_v_rise = v & ~r_v_q;
  assign w_h_rise = h & ~r_h_q;

  // State register, capture position and strobe history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_h_q   <= 1'b0;
      r_v_q   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_y     <= w_y_next;
      r_h_q   <= h;
      r_v_q   <= v;
    end
  end

  // Next-state: apply v/h strobes first (v wins), then advance on the pixel strobe
  always_comb begin
    w_state_next = r_state;
    w_wx         = r_x;
    w_wy         = r_y;
    w_capture    = 1'b0;
    w_set_abort  = 1'b0;
    w_set_short  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_v_rise) begin
          w_wx      = '0;
          w_wy      = '0;
          w_capture = 1'b1;
        end
      end
      S_ACTIVE: begin
        w_capture = 1'b1;
        if (w_v_rise) begin
          w_set_abort = 1'b1;
          w_wx        = '0;
          w_wy        = '0;
        end else if (w_h_rise && (r_x != '0)) begin
          // Line cut short: the rest of this line is left unwritten
          w_set_short = 1'b1;
          w_wx        = '0;
          if (r_y == YW'(V_ACTIVE - 1)) begin
            w_capture    = 1'b0;
            w_state_next = S_DONE;
          end else begin
            w_wy = r_y + YW'(1);
          end
        end
      end
      S_HWAIT: begin
        if (w_v_rise) begin
          w_set_abort = 1'b1;
          w_wx        = '0;
          w_wy        = '0;
          w_capture   = 1'b1;
        end else if (w_h_rise) begin
          w_wx        = '0;
          w_wy        = r_y + YW'(1);
          w_capture   = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    w_x_next = w_wx;
    w_y_next = w_wy;
    if (w_capture) begin
      w_state_next = S_ACTIVE;
      if (pix_en) begin
        if (w_wx == XW'(H_ACTIVE - 1)) begin
          w_x_next     = '0;
          w_state_next = (w_wy == YW'(V_ACTIVE - 1)) ? S_DONE : S_HWAIT;
        end else begin
          w_x_next = w_wx + XW'(1);
        end
      end
    end
  end

  // Outputs of the FSM: write strobe/address and the one-cycle swap in DONE
  always_comb begin
    w_wr_en   = w_capture & pix_en;
    w_wr_addr = ADDR_W'(w_wy) * ADDR_W'(H_ACTIVE) + ADDR_W'(w_wx);
    w_swap    = (r_state == S_DONE);
  end

  // Bank swap, completed-frame counter and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_front_bank  <= 1'b0;
      r_frame_count <= 16'd0;
      r_err_abort   <= 1'b0;
      r_err_short   <= 1'b0;
    end else begin
      if (w_swap) begin
        r_front_bank  <= ~r_front_bank;
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_set_abort) r_err_abort <= 1'b1;
      if (w_set_short) r_err_short <= 1'b1;
    end
  end

  // Frame store write port; the back bank is always the complement of the front bank
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[{~r_front_bank, w_wr_addr}] <= pixel_in;
    end
  end

  // Registered read from the front bank as seen in the request cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_req;
      if (rd_req) begin
        if ({1'b0, rd_addr} < (ADDR_W + 1)'(FRAME_PIX)) begin
          r_rd_data <= r_mem[{r_front_bank, rd_addr}];
        end else begin
          r_rd_data <= '0;
        end
      end
    end
  end

  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign frame_ready = w_swap;
  assign front_bank  = r_front_bank;
  assign frame_count = r_frame_count;
  assign err_abort   = r_err_abort;
  assign err_short   = r_err_short;

endmodule
